add_accum_wb: RTL
=================

// Module: add_accum_wb
// PURPOSE
//  Downstream stage of the ADD-layer input address generator. Takes the feature
//  beats that generator reads from the IO buffer (in_piece consecutive pieces per
//  output pixel) and sums them lane-wise with signed saturation. Writes one result
//  word per pixel to the output buffer at addr_start_w + pixel index.
//  Pulses layer-done after out_x_length*out_y_length writes.
// PARAMETERS
//  LANES   8   int8 lanes per buffer word
//  ELEM_W  8   bits per lane (signed two's complement)
//  ADDR_W  13  buffer address width
//  RD_LAT  2   IO-buffer read latency, cycles from i_rd_en to valid i_rd_data
// PORTS
//  clk              in   1               clock, rising edge
//  rst              in   1               asynchronous reset, active-low
//  start_calculate  in   1               1-cycle layer start pulse from schedule
//  addr_start_w     in   ADDR_W          output base address (decoder)
//  out_x_length     in   8               output width in pixels
//  out_y_length     in   8               output height in pixels
//  in_piece         in   8               pieces summed per pixel
//  i_rd_en          in   1               read strobe issued by the input AGU
//  i_rd_data        in   LANES*ELEM_W    IO-buffer read data
//  o_wr_addr        out  ADDR_W          output-buffer write address
//  o_wr_data        out  LANES*ELEM_W    saturated sum
//  o_wr_en          out  1               write strobe, 1 cycle per pixel
//  o_layer_done     out  1               1-cycle pulse, layer complete
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, FSM IDLE, all counters and accumulator 0.
//  - FSM IDLE -> RUN on start_calculate.
//    - Config latched on that edge.
//    - in_piece==0 is latched as 1.
//    - total = out_x_length*out_y_length, 16 bits.
//    - If total==0: go to DONE, no writes.
//  - RUN:
//    - vld = i_rd_en delayed by RD_LAT through a shift register.
//    - The shift register is cleared on reset and on start.
//    - On each vld beat, piece_cnt increments.
//    - piece_cnt==0 loads the accumulator with the beat.
//    - Later beats add lane-wise, saturating to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1].
//    - Saturation is applied after each add, not only at the end.
//  - Last piece (piece_cnt==in_piece-1):
//    - Next cycle: o_wr_en=1, o_wr_data = final sum, o_wr_addr = addr_start_w + pix_cnt.
//    - Address is truncated to ADDR_W and wraps modulo 2^ADDR_W.
//    - piece_cnt returns to 0 and pix_cnt increments.
//    - Back-to-back last beats give back-to-back writes. No bubbles, no backpressure.
//  - After write number total: FSM -> DONE. Next cycle o_layer_done=1, then IDLE.
//  - Outputs are registered. o_wr_en/o_layer_done are 0 on every cycle not named above.
//  - start_calculate while RUN/DONE: ignored.
//  - vld in IDLE/DONE: ignored, accumulator untouched.
//  - Reset mid-layer: immediate abort to IDLE. No partial write, no done pulse.
// STRUCTURE
//  - Shared package (npu_add_pkg): LANES, ELEM_W, ADDR_W, RD_LAT; state enum IDLE/RUN/DONE.
//  - One sub-module, sat_add_lane: combinational signed ELEM_W add with clamp.
//    Instantiated LANES times.
//  - Top holds the FSM, the vld delay line, piece/pixel counters, the accumulator
//    and the output registers.
// TESTING
//  1. x=2,y=2,piece=2, base=0x100, beats lane0 = 1,2 | 3,4 | 5,6 | 7,8:
//     -> writes 0x100..0x103 with lane0 = 3,7,11,15, then one o_layer_done.
//  2. piece=3, lane beats 100,50,-20:
//     -> 100+50 clamps to 127, then 127-20 = 107 written (step-wise saturation).
//     Beats -100,-100 -> -128.
//  3. x=3,y=0 -> no o_wr_en, o_layer_done exactly 1 cycle after IDLE->DONE.
//     in_piece=0 behaves exactly as in_piece=1.
//  4. base=0x1FFE, x=4,y=1, piece=1 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
//  5. Continuous rd_en, piece=1, x=8,y=1 -> 8 consecutive-cycle writes.
//     First write RD_LAT+1 cycles after the first i_rd_en.
//  6. rst low after 2 of 4 writes -> outputs 0 immediately, no done.
//     A fresh start then completes normally.
//     A second start_calculate mid-RUN has no effect.

Source files
------------

// File: rtl/npu_add_pkg.sv
// Shared parameters and state type for the ADD-layer accumulate/write-back stage.
package npu_add_pkg;

  localparam int LANES  = 8;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 13;
  localparam int RD_LAT = 2;
  localparam int DATA_W = LANES * ELEM_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add_lane.sv
// One signed lane adder that clamps to the representable ELEM_W range.
module sat_add_lane
  import npu_add_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] sum
);

  localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

  logic [ELEM_W:0] wide;

  // One extra bit of headroom; the top two bits disagree exactly on overflow.
  always_comb begin
    wide = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
    if (wide[ELEM_W] != wide[ELEM_W-1]) begin
      sum = wide[ELEM_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = wide[ELEM_W-1:0];
    end
  end

endmodule

// File: rtl/add_accum_wb.sv
// Sums in_piece feature beats per output pixel lane-wise with saturation and
// writes one word per pixel to the output buffer, then pulses layer-done.
//
//   state | meaning
//   IDLE  | waiting for start_calculate, beats ignored
//   RUN   | accumulating beats, one write per completed pixel
//   DONE  | all pixels written, layer-done pulse issued next cycle
module add_accum_wb
  import npu_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calculate,
  input  logic [ADDR_W-1:0] addr_start_w,
  input  logic [7:0]        out_x_length,
  input  logic [7:0]        out_y_length,
  input  logic [7:0]        in_piece,
  input  logic              i_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_en,
  output logic              o_layer_done
);

  state_t state, state_nxt;

  logic [RD_LAT-1:0] vld_sr;
  logic              vld;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        piece_q;
  logic [15:0]       total_q;
  logic [15:0]       total_in;
  logic [7:0]        piece_cnt;
  logic [15:0]       pix_cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_op;
  logic [DATA_W-1:0] sum;
  logic              start_ok;
  logic              beat_ok;
  logic              last_piece;
  logic              last_pix;
  logic              wr_fire;
  logic              done_fire;

  assign vld        = vld_sr[RD_LAT-1];
  assign total_in   = {8'd0, out_x_length} * {8'd0, out_y_length};
  assign start_ok   = (state == IDLE) && start_calculate;
  assign beat_ok    = (state == RUN) && vld;
  assign last_piece = (piece_cnt == piece_q - 8'd1);
  assign last_pix   = (pix_cnt == total_q - 16'd1);

  // The first piece of a pixel adds to zero, which loads the beat unchanged.
  assign acc_op = (piece_cnt == 8'd0) ? '0 : acc;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sat_add_lane u_lane (
      .a   (acc_op[l*ELEM_W +: ELEM_W]),
      .b   (i_rd_data[l*ELEM_W +: ELEM_W]),
      .sum (sum[l*ELEM_W +: ELEM_W])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and write/done strobes.
  always_comb begin
    state_nxt = state;
    wr_fire   = 1'b0;
    done_fire = 1'b0;
    case (state)
      IDLE: begin
        if (start_calculate) state_nxt = (total_in == 16'd0) ? DONE : RUN;
      end
      RUN: begin
        if (beat_ok && last_piece) begin
          wr_fire = 1'b1;
          if (last_pix) state_nxt = DONE;
        end
      end
      DONE: begin
        done_fire = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read-valid delay line matching the IO-buffer latency; flushed on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          vld_sr <= '0;
    else if (start_ok) vld_sr <= '0;
    else               vld_sr <= (vld_sr << 1) | RD_LAT'(i_rd_en);
  end

  // Layer configuration captured at start; zero pieces is treated as one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      piece_q <= '0;
      total_q <= '0;
    end else if (start_ok) begin
      base_q  <= addr_start_w;
      piece_q <= (in_piece == 8'd0) ? 8'd1 : in_piece;
      total_q <= total_in;
    end
  end

  // Piece/pixel counters and running accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      piece_cnt <= '0;
      pix_cnt   <= '0;
      acc       <= '0;
    end else if (start_ok) begin
      piece_cnt <= '0;
      pix_cnt   <= '0;
      acc       <= '0;
    end else if (beat_ok) begin
      acc <= sum;
      if (last_piece) begin
        piece_cnt <= '0;
        pix_cnt   <= pix_cnt + 16'd1;
      end else begin
        piece_cnt <= piece_cnt + 8'd1;
      end
    end
  end

  // Registered outputs; address wraps naturally at ADDR_W bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_wr_en      <= 1'b0;
      o_layer_done <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
    end else begin
      o_wr_en      <= wr_fire;
      o_layer_done <= done_fire;
      if (wr_fire) begin
        o_wr_addr <= base_q + pix_cnt[ADDR_W-1:0];
        o_wr_data <= sum;
      end
    end
  end

endmodule
